// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, halt causes
// and the default reset vector.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        HC_NONE      = 2'd0,
        HC_EXCEPTION = 2'd1,
        HC_MISALIGN  = 2'd2,
        HC_TIMEOUT   = 2'd3
    } halt_cause_e;

    localparam logic [31:0] RESETVEC_DEFAULT = 32'h0000_0000;

    // Sequential fetch advance; wraps silently at the top of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the imem request handshake, pipeline controls and decode-buffer
// outputs seen by the fetch sequencer.
interface fetch_ctrl_if;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        exception;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_flush;
    logic        halted;
    logic [1:0]  halt_cause;

    modport master (
        output imem_ready, imem_addr, id_valid, id_inst, id_pc, id_flush,
               halted, halt_cause,
        input  imem_valid, imem_rdata, stall, ex_redirect, ex_target, exception
    );

    modport slave (
        input  imem_ready, imem_addr, id_valid, id_inst, id_pc, id_flush,
               halted, halt_cause,
        output imem_valid, imem_rdata, stall, ex_redirect, ex_target, exception
    );
endinterface

// File: rtl/fetch_ctrl_buf.sv
// One-entry decode buffer: kill clears the valid bit, load captures a new
// instruction, otherwise the contents hold.
module fetch_buf #(
    parameter logic [31:0] RESETVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        load_i,
    input  logic        kill_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (resetb) begin
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            pc_q    <= RESETVEC;
        end else if (kill_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign id_valid_o = valid_q;
    assign id_inst_o  = inst_q;
    assign id_pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the imem request and applies
// exception > redirect > stall > transfer priority each cycle.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESETVEC = RESETVEC_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         resetb,
    fetch_ctrl_if.master bus
);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    fetch_state_e  state_q;
    halt_cause_e   cause_q;
    logic [31:0]   pc_q;
    logic [WW-1:0] wait_q;
    logic          flush_q;

    logic in_fetch, req, waiting, buf_load, buf_kill;

    always_comb begin
        in_fetch = (state_q == ST_FETCH);
        req      = in_fetch && !bus.stall;
        waiting  = req && !bus.imem_valid;
        // Any exception or redirect squashes a same-cycle transfer.
        buf_load = req && bus.imem_valid && !bus.exception && !bus.ex_redirect;
        buf_kill = in_fetch && (bus.exception || bus.ex_redirect || waiting);
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q <= ST_BOOT;
            cause_q <= HC_NONE;
            pc_q    <= RESETVEC;
            wait_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                ST_BOOT: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.exception) begin
                        state_q <= ST_HALT;
                        cause_q <= HC_EXCEPTION;
                    end else if (bus.ex_redirect) begin
                        if (bus.ex_target[1:0] != 2'b00) begin
                            state_q <= ST_HALT;
                            cause_q <= HC_MISALIGN;
                        end else begin
                            pc_q    <= bus.ex_target;
                            wait_q  <= '0;
                            flush_q <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        if (bus.imem_valid) begin
                            pc_q   <= pc_inc(pc_q);
                            wait_q <= '0;
                        end else if (wait_q == WW'(TIMEOUT - 1)) begin
                            state_q <= ST_HALT;
                            cause_q <= HC_TIMEOUT;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    fetch_buf #(.RESETVEC(RESETVEC)) u_buf (
        .clk       (clk),
        .resetb    (resetb),
        .load_i    (buf_load),
        .kill_i    (buf_kill),
        .inst_i    (bus.imem_rdata),
        .pc_i      (pc_q),
        .id_valid_o(bus.id_valid),
        .id_inst_o (bus.id_inst),
        .id_pc_o   (bus.id_pc)
    );

    assign bus.imem_ready = req;
    assign bus.imem_addr  = pc_q;
    assign bus.id_flush   = flush_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.halt_cause = cause_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_ctrl;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          TO = 16;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESETVEC(RV), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    typedef struct {
        bit          chk_comb;
        bit          ready;
        logic [31:0] addr;
        bit          idv;
        bit          chk_id;
        logic [31:0] inst;
        logic [31:0] idpc;
        bit          flush;
        bit          halted;
        logic [1:0]  cause;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: what the core should look like after each edge.
    bit          m_known = 0, m_dead, m_halted, m_flush, m_idv, m_idknown;
    logic [31:0] m_pc, m_inst, m_idpc;
    logic [1:0]  m_cause;
    int          m_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic m_halt(input logic [1:0] c);
        m_halted = 1;
        m_idv    = 0;
        m_cause  = c;
    endtask

    task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] tgt,
                       input bit ex, input bit iv);
        exp_t        e;
        logic [31:0] rdata;
        @(negedge clk);
        rdata           = $urandom;
        resetb          = rst;
        bus.stall       = st;
        bus.ex_redirect = rd;
        bus.ex_target   = tgt;
        bus.exception   = ex;
        bus.imem_valid  = iv;
        bus.imem_rdata  = rdata;
        if (m_known) begin
            e.chk_comb = !rst;
            e.ready    = !m_dead && !m_halted && !st;
            e.addr     = m_pc;
            e.idv      = m_idv;
            e.chk_id   = m_idv || m_idknown;
            e.inst     = m_inst;
            e.idpc     = m_idpc;
            e.flush    = m_flush;
            e.halted   = m_halted;
            e.cause    = m_cause;
            sbq.push_back(e);
        end
        if (rst) begin
            m_known = 1; m_dead = 1; m_halted = 0; m_flush = 0; m_pc = RV; m_wait = 0;
            m_idv = 0; m_inst = 0; m_idpc = RV; m_idknown = 1; m_cause = 0;
        end else if (m_known) begin
            m_flush = 0;
            if (m_dead) m_dead = 0;
            else if (!m_halted) begin
                if (ex) m_halt(2'd1);
                else if (rd && tgt[1:0] != 2'b00) m_halt(2'd2);
                else if (rd) begin
                    m_pc = tgt; m_idv = 0; m_flush = 1; m_wait = 0;
                end else if (!st) begin
                    if (iv) begin
                        m_inst = rdata; m_idpc = m_pc; m_idv = 1; m_idknown = 0;
                        m_pc = m_pc + 32'd4; m_wait = 0;
                    end else begin
                        m_idv = 0;
                        m_wait++;
                        if (m_wait == TO) m_halt(2'd3);
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 1);
    endtask

    // Monitor: pops one expectation per cycle once outputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk_comb) begin
                    chk("imem_ready", bus.imem_ready, e.ready);
                    if (e.ready) chk("imem_addr", bus.imem_addr, e.addr);
                end
                chk("id_valid", bus.id_valid, e.idv);
                if (e.chk_id) begin
                    chk("id_inst", bus.id_inst, e.inst);
                    chk("id_pc", bus.id_pc, e.idpc);
                end
                chk("id_flush", bus.id_flush, e.flush);
                chk("halted", bus.halted, e.halted);
                chk("halt_cause", bus.halt_cause, e.cause);
            end
        end
    end

    initial begin
        int          burst;
        logic [31:0] t;
        resetb = 1; bus.stall = 0; bus.ex_redirect = 0; bus.ex_target = 0;
        bus.exception = 0; bus.imem_valid = 0; bus.imem_rdata = 0;

        // Reset, dead cycle, streaming fetch 0,4 then three waits at 0x8.
        cyc(1, 0, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
        run(3);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        run(2);
        // Redirect to 0x100 while 0x10 transfers.
        cyc(0, 0, 1, 32'h100, 0, 1);
        run(3);
        // Move to 0x20, stall twice with a redirect to 0x40 in the second stall.
        cyc(0, 0, 1, 32'h20, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 1, 32'h40, 0, 1);
        run(3);
        // Misaligned redirect halts; later exceptions/redirects are ignored.
        cyc(0, 0, 1, 32'h102, 0, 1);
        run(2);
        cyc(0, 0, 1, 32'h200, 1, 1);
        run(2);
        cyc(1, 0, 0, 0, 0, 1);
        run(4);
        // Timeout: RAM never answers.
        repeat (TO + 3) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        run(3);
        // Exception and redirect together: exception wins.
        cyc(0, 0, 1, 32'h300, 1, 1);
        run(3);
        // Wrap at the top of the address space.
        cyc(1, 0, 0, 0, 0, 1);
        run(2);
        cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 1);
        run(4);

        // Random traffic with occasional long no-response bursts.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            else if (t[1:0] == 2'b00) t[0] = 1'b1;
            if (burst > 0) burst--;
            else if ($urandom_range(0, 99) == 0) burst = $urandom_range(10, 20);
            cyc((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0, t,
                $urandom_range(0, 63) == 0, (burst == 0) && ($urandom_range(0, 4) != 0));
        end
        run(3);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
